// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with optional two-entry skid buffer
// Holds up to two payloads in order; main always feeds the output, skid catches the overflow.
module pipe_stage_reg #(
  parameter int PAYLOAD_W   = 110,
  parameter int SKID_EN     = 1,
  parameter int BUBBLE_ZERO = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic SKID = (SKID_EN != 0);
  localparam logic BZ   = (BUBBLE_ZERO != 0);

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 ready_q, ready_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_fire;
  logic                 out_fire;

  assign out_valid = (state_q != S_EMPTY);
  assign occupancy = state_q;
  // Skid mode uses a registered ready so upstream never sees a combinational path from out_ready.
  assign in_ready  = SKID ? ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = (BZ && !out_valid) ? '0 : main_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && SKID) begin
            state_d = S_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    ready_d = (state_d != S_TWO);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
